// File: rtl/coin_btn_conditioner.sv
// Coin-sensor pulse-width classifier and purchase-button debouncer feeding the vending FSM.
// Emits one-cycle w100/btn/rej pulses (never overlapping) and a jam level.
module coin_btn_conditioner #(
  parameter int DEB_CYC  = 4,
  parameter int COIN_MIN = 3,
  parameter int COIN_MAX = 20,
  parameter int HOLDOFF  = 8
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic coin_raw,
  input  logic btn_raw,
  output logic w100,
  output logic btn,
  output logic rej,
  output logic jam
);

  localparam int CNT_W = $clog2(COIN_MAX + 2);
  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam int GAP_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [CNT_W-1:0] L_MIN      = CNT_W'(COIN_MIN);
  localparam logic [CNT_W-1:0] L_MAX      = CNT_W'(COIN_MAX);
  localparam logic [DEB_W-1:0] L_DEB      = DEB_W'(DEB_CYC);
  localparam logic [GAP_W-1:0] L_GAP_LAST = GAP_W'(HOLDOFF - 1);

  typedef enum logic [1:0] {S_IDLE, S_MEAS, S_JAM, S_GAP} state_t;

  logic             r_coin_s1, r_coin_s2, r_btn_s1, r_btn_s2;
  logic [1:0]       r_sync_vld;
  logic             r_coin_low;
  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_btn_d, r_btn_dq, r_btn_pend;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [GAP_W-1:0] r_gap;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt, w_cnt_inc;
  logic [GAP_W-1:0] w_gap_nxt;
  logic [DEB_W-1:0] w_deb_inc;
  logic             w_acc, w_rej_ev, w_btn_ev, w_busy;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_deb_inc = r_deb_cnt + 1'b1;
  assign w_btn_ev  = r_btn_d & ~r_btn_dq;
  assign w_busy    = w_acc | w_rej_ev;

  // Synchronizers; r_sync_vld marks when coin_s reflects real post-reset input,
  // so a coin already present at reset release never looks like a fresh rising edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_coin_s1  <= 1'b0;
      r_coin_s2  <= 1'b0;
      r_btn_s1   <= 1'b0;
      r_btn_s2   <= 1'b0;
      r_sync_vld <= 2'b00;
      r_coin_low <= 1'b0;
    end else begin
      r_coin_s1  <= coin_raw;
      r_coin_s2  <= r_coin_s1;
      r_btn_s1   <= btn_raw;
      r_btn_s2   <= r_btn_s1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      r_coin_low <= r_sync_vld[1] & ~r_coin_s2;
    end
  end

  // Debounce: level follows btn_s only after DEB_CYC consecutive disagreeing cycles
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_deb_cnt <= '0;
      r_btn_d   <= 1'b0;
      r_btn_dq  <= 1'b0;
    end else begin
      r_btn_dq <= r_btn_d;
      if (r_btn_s2 != r_btn_d) begin
        if (w_deb_inc == L_DEB) begin
          r_btn_d   <= r_btn_s2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= w_deb_inc;
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_acc       = 1'b0;
    w_rej_ev    = 1'b0;
    case (r_state)
      // A new coin needs a low-to-high edge seen in IDLE
      S_IDLE: begin
        if (r_coin_s2 && r_coin_low) begin
          w_state_nxt = S_MEAS;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      S_MEAS: begin
        if (r_coin_s2) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc > L_MAX) w_state_nxt = S_JAM;
        end else begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = '0;
          if (r_cnt >= L_MIN && r_cnt <= L_MAX) w_acc = 1'b1;
          else                                  w_rej_ev = 1'b1;
        end
      end
      S_JAM: begin
        if (!r_coin_s2) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = '0;
          w_rej_ev    = 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap == L_GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A button press colliding with a coin decision is deferred one cycle; only one is held
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      w100       <= 1'b0;
      rej        <= 1'b0;
      jam        <= 1'b0;
      btn        <= 1'b0;
      r_btn_pend <= 1'b0;
    end else begin
      w100 <= w_acc;
      rej  <= w_rej_ev;
      jam  <= (w_state_nxt == S_JAM);
      if (w_busy) begin
        btn <= 1'b0;
        if (w_btn_ev) r_btn_pend <= 1'b1;
      end else if (r_btn_pend) begin
        btn        <= 1'b1;
        r_btn_pend <= 1'b0;
      end else begin
        btn <= w_btn_ev;
      end
    end
  end

endmodule

// File: doc/coin_btn_conditioner.md
COIN_BTN_CONDITIONER -- requirements
Module: coin_btn_conditioner

Interface
REQ-001 Parameter DEB_CYC, default 4, number of consecutive stable cycles required before the debounced button level changes.
REQ-002 Parameter COIN_MIN, default 3, minimum accepted coin-sensor high width in cycles.
REQ-003 Parameter COIN_MAX, default 20, maximum accepted coin-sensor high width in cycles.
REQ-004 Parameter HOLDOFF, default 8, dead cycles after any coin decision before a new coin is measured.
REQ-005 CLK  input  1  system clock; one clock; all state on rising edge.
REQ-006 RST_N  input  1  reset, asynchronous, active-low.
REQ-007 coin_raw  input  1  asynchronous coin sensor, high while a coin passes.
REQ-008 btn_raw  input  1  asynchronous, bouncing purchase button, high = pressed.
REQ-009 w100  output  1  one-cycle pulse per accepted 100-won coin, to the vending FSM.
REQ-010 btn  output  1  one-cycle pulse per debounced button press, to the vending FSM.
REQ-011 rej  output  1  one-cycle pulse per rejected coin (mechanical return).
REQ-012 jam  output  1  level; high while the coin sensor has been high longer than COIN_MAX.

Function
REQ-013 coin_raw and btn_raw SHALL each pass a 2-flop synchronizer (coin_s, btn_s); all logic uses only the synchronized values.
REQ-014 Debounced button level btn_d SHALL toggle only after btn_s differs from btn_d for DEB_CYC consecutive cycles; any intermediate agreement clears the counter.
REQ-015 A btn pulse SHALL be produced on the cycle after btn_d goes 0->1; no pulse on release; a held button produces exactly one pulse.
REQ-016 Coin FSM states: IDLE, MEAS, JAM, GAP.
REQ-017 IDLE: coin_s=1 -> MEAS with cnt=1; else stay.
REQ-018 MEAS: coin_s=1 -> cnt+1; if the new cnt would exceed COIN_MAX -> JAM.
REQ-019 MEAS: coin_s=0 -> GAP; w100 pulses in that transition cycle if COIN_MIN<=cnt<=COIN_MAX, else rej pulses.
REQ-020 JAM: jam=1 every cycle in JAM; coin_s=0 -> GAP with one rej pulse; no w100 is ever produced from JAM.
REQ-021 GAP: counts HOLDOFF cycles, then -> IDLE; coin_s activity during GAP is ignored and does not restart the count.
REQ-022 If coin_s is still high when GAP ends, IDLE SHALL not start MEAS until coin_s has been seen low at least once (no double count).
REQ-023 cnt SHALL be sized to hold COIN_MAX+1 and never wraps.
REQ-024 w100, btn and rej SHALL never be high in the same cycle as each other.
REQ-025 If btn and w100 fall due in the same cycle, w100 is issued and btn is issued in the next cycle; at most one pending btn is held, and additional presses while it is pending are dropped.
REQ-026 w100 and rej are mutually exclusive by construction; neither is ever delayed.
REQ-027 Latency: the w100/rej pulse occurs 3 cycles after the coin_raw falling edge (2 synchronizer + 1 FSM), with no extra delay except as given in REQ-025 for btn.

Reset
REQ-028 RST_N low SHALL immediately force w100=0, btn=0, rej=0, jam=0, FSM=IDLE, cnt=0, debounce counter=0, btn_d=0, pending btn cleared, synchronizers=0.
REQ-029 A coin in progress when reset asserts SHALL be discarded; after release the REQ-022 rule applies, so no pulse is issued for it.
REQ-030 Outputs SHALL be glitch-free registered signals from the first CLK edge after RST_N deasserts.

Verification
REQ-031 coin_raw high for 5 cycles -> one w100 pulse 3 cycles after the fall; rej=0, jam=0.
REQ-032 coin_raw high for 2 cycles, then separately for 21 cycles -> one rej pulse for the first; jam high from the cycle cnt would reach 21 until the fall, then one rej; no w100.
REQ-033 btn_raw bouncing 1,0,1,0 at single cycles, then stable high for 10 cycles -> exactly one btn pulse; release with bounces -> no pulse.
REQ-034 Button debounce completes in the same cycle a valid coin ends -> w100 in cycle N, btn in cycle N+1.
REQ-035 Second 5-cycle coin starts 2 cycles after the first w100 (inside GAP) and ends inside GAP -> no second w100 and no rej.
REQ-036 RST_N pulsed low mid-MEAS (cnt=4) with coin still high, released with coin high for 6 more cycles -> no w100/rej; the next clean 5-cycle coin produces w100.
